task_display_mux: RTL and testbench
===================================

TASK_DISPLAY_MUX -- requirements
Module: task_display_mux

Interface
REQ-001 The block SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 The block SHALL provide these parameters:
- N_TASKS, default 4: number of task channels, 1..16.
- COLOUR_W, default 16: OLED colour width (RGB565).
- TICK_DIV, default 10000: clk cycles per switch sample tick (10 kHz at 100 MHz).
- DEBOUNCE_TICKS, default 4: consecutive equal samples required before a request is accepted.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: 100 MHz system clock.
- reset, in, 1: synchronous active-high reset.
- task_sw, in, N_TASKS: asynchronous task request switches; bit 0 has highest priority.
- frame_begin, in, 1: OLED frame-start strobe, synchronous to clk.
- colour_in, in, N_TASKS*COLOUR_W: per-task pixel colour; task k occupies bits [k*COLOUR_W +: COLOUR_W].
- default_colour, in, COLOUR_W: colour shown when no task is active.
- task_en, out, N_TASKS: committed one-hot task enable, or all zero.
- active_id, out, 5: index of the committed task; 31 when none is active.
- pixel_out, out, COLOUR_W: registered colour sent to the OLED driver.
- seg_en, out, 1: 7-segment enable; 1 only when no task is active.
- switch_pulse, out, 1: one-cycle strobe when the committed selection changes.

Function
REQ-004 A tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; a tick SHALL be asserted in the cycle where the count equals TICK_DIV-1.
REQ-005 task_sw SHALL pass through a 2-flop synchroniser before any use.
REQ-006 On each tick, the synchronised switches SHALL be priority-encoded into a candidate: one-hot at the lowest set index, or zero if no bit is set.
REQ-007 A candidate SHALL become the stable selection only after DEBOUNCE_TICKS consecutive ticks with an identical candidate; any differing sample SHALL restart the count at 1.
REQ-008 The stable selection SHALL be copied into the committed selection only in a cycle where frame_begin=1; selection changes SHALL never take effect mid-frame.
REQ-009 If stable changes in the same cycle that frame_begin=1, the value stable held before that cycle SHALL be committed; the new value SHALL commit at the next frame_begin.
REQ-010 task_en SHALL equal the committed selection; active_id SHALL be its binary index, or 31 when it is zero.
REQ-011 pixel_out SHALL be registered with 1-cycle latency: colour_in slice of the committed task, or default_colour when no task is active.
REQ-012 seg_en SHALL be registered and equal 1 exactly when the committed selection is zero.
REQ-013 switch_pulse SHALL be 1 for exactly one cycle, the cycle after a commit that changes the committed value; a commit of an unchanged value SHALL not pulse.
REQ-014 Switch bits at index N_TASKS and above SHALL not exist, so no out-of-range index can be produced.

Reset
REQ-015 While reset=1, the block SHALL drive task_en=0, active_id=31, pixel_out=0, seg_en=1, switch_pulse=0.
REQ-016 While reset=1, the block SHALL clear the tick counter, synchroniser flops, debounce count, stable selection and committed selection.
REQ-017 Reset asserted mid-debounce or mid-frame SHALL discard all pending state; a request SHALL need a full DEBOUNCE_TICKS again after reset is released.

Structure
REQ-018 A shared package SHALL hold:
- default values of COLOUR_W, TICK_DIV and DEBOUNCE_TICKS;
- the NONE_ID constant (31);
- the active_id width constant (5).
REQ-019 The synchroniser, tick counter and debounce logic SHALL be one sub-module, switch_debouncer, parametrised by width, TICK_DIV and DEBOUNCE_TICKS.
REQ-020 Priority encoding, frame-aligned commit and the output mux SHALL reside in task_display_mux.

Verification
Bench parameters: N_TASKS=4, TICK_DIV=4, DEBOUNCE_TICKS=3.
REQ-021 Set task_sw=4'b0110 and pulse frame_begin after 12+ cycles -> task_en=4'b0010, active_id=1, seg_en=0, switch_pulse high for one cycle, pixel_out=colour_in[31:16] one cycle later.
REQ-022 Toggle task_sw[2] every 2 ticks, then hold it with frame_begin pulsing every 8 cycles -> committed selection unchanged while toggling; 4'b0100 commits at the first frame_begin after 3 stable ticks.
REQ-023 Make stable change in the same cycle as a frame_begin pulse -> the old value is committed; the new value commits at the next frame_begin; one switch_pulse per actual change.
REQ-024 Clear all switches with selection 4'b0001 committed -> after debounce and frame_begin, task_en=0, active_id=31, seg_en=1, pixel_out=default_colour (e.g. 16'h07E0).
REQ-025 Assert reset mid-debounce with task_sw=4'b1000 held -> outputs take reset values; commit needs 3 full ticks plus a frame_begin after reset is released.

Source files
------------

// File: rtl/task_display_mux_pkg.sv
// Shared constants and helpers for the task display multiplexer.
package task_display_mux_pkg;

  localparam int COLOUR_W_DEF       = 16;
  localparam int TICK_DIV_DEF       = 10000;
  localparam int DEBOUNCE_TICKS_DEF = 4;

  // Width of active_id and the code reported when no task is committed.
  localparam int              ID_W    = 5;
  localparam logic [ID_W-1:0] NONE_ID = 5'd31;

  // Upper bound on task channels; helpers work on vectors this wide.
  localparam int MAX_TASKS = 16;

  // Keep only the lowest set bit (highest priority request).
  function automatic logic [MAX_TASKS-1:0] lowest_set(input logic [MAX_TASKS-1:0] v);
    logic [MAX_TASKS-1:0] r;
    r = {MAX_TASKS{1'b0}};
    for (int k = MAX_TASKS - 1; k >= 0; k--) begin
      if (v[k]) begin
        r    = {MAX_TASKS{1'b0}};
        r[k] = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Binary index of a one-hot vector, NONE_ID when the vector is zero.
  function automatic logic [ID_W-1:0] onehot_to_id(input logic [MAX_TASKS-1:0] sel);
    logic [ID_W-1:0] id;
    id = NONE_ID;
    for (int k = MAX_TASKS - 1; k >= 0; k--) begin
      if (sel[k]) begin
        id = ID_W'(k);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/task_display_mux_switch_debouncer.sv
// Switch conditioning: 2-flop synchroniser, sample tick divider and a
// consecutive-sample debouncer for the priority-encoded candidate.
module switch_debouncer
  import task_display_mux_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_sync,
  input  logic [WIDTH-1:0] candidate,
  output logic [WIDTH-1:0] stable
);

  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DCNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_TICKS);

  logic [WIDTH-1:0]  sync1_r;
  logic [WIDTH-1:0]  sync2_r;
  logic [TCNT_W-1:0] tcnt_r;
  logic              tick_s;
  logic [WIDTH-1:0]  last_r;
  logic [WIDTH-1:0]  last_next_s;
  logic [DCNT_W-1:0] dcnt_r;
  logic [DCNT_W-1:0] dcnt_next_s;
  logic [WIDTH-1:0]  stable_r;
  logic [WIDTH-1:0]  stable_next_s;

  // Two-flop synchroniser for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  assign sw_sync = sync2_r;
  assign tick_s  = (tcnt_r == TCNT_MAX);

  // Free-running sample divider, wraps after TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_r <= {TCNT_W{1'b0}};
    end else if (tick_s) begin
      tcnt_r <= {TCNT_W{1'b0}};
    end else begin
      tcnt_r <= tcnt_r + TCNT_W'(1);
    end
  end

  // Count identical samples; a zero count means no sample since reset,
  // so the first sample always starts a fresh run at 1.
  always_comb begin
    dcnt_next_s   = dcnt_r;
    last_next_s   = last_r;
    stable_next_s = stable_r;
    if (tick_s) begin
      if ((candidate == last_r) && (dcnt_r != {DCNT_W{1'b0}})) begin
        if (dcnt_r < DCNT_MAX) begin
          dcnt_next_s = dcnt_r + DCNT_W'(1);
        end else begin
          dcnt_next_s = dcnt_r;
        end
      end else begin
        dcnt_next_s = DCNT_W'(1);
        last_next_s = candidate;
      end
      if (dcnt_next_s == DCNT_MAX) begin
        stable_next_s = candidate;
      end else begin
        stable_next_s = stable_r;
      end
    end else begin
      dcnt_next_s   = dcnt_r;
      last_next_s   = last_r;
      stable_next_s = stable_r;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_r   <= {DCNT_W{1'b0}};
      last_r   <= {WIDTH{1'b0}};
      stable_r <= {WIDTH{1'b0}};
    end else begin
      dcnt_r   <= dcnt_next_s;
      last_r   <= last_next_s;
      stable_r <= stable_next_s;
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/task_display_mux.sv
// Task display multiplexer: picks the highest-priority debounced task,
// commits it only on OLED frame boundaries and muxes its pixel colour.
module task_display_mux
  import task_display_mux_pkg::*;
#(
  parameter int N_TASKS        = 4,
  parameter int COLOUR_W       = COLOUR_W_DEF,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_TASKS-1:0]          task_sw,
  input  logic                        frame_begin,
  input  logic [N_TASKS*COLOUR_W-1:0] colour_in,
  input  logic [COLOUR_W-1:0]         default_colour,
  output logic [N_TASKS-1:0]          task_en,
  output logic [ID_W-1:0]             active_id,
  output logic [COLOUR_W-1:0]         pixel_out,
  output logic                        seg_en,
  output logic                        switch_pulse
);

  logic [N_TASKS-1:0]  sw_sync_s;
  logic [N_TASKS-1:0]  candidate_s;
  logic [N_TASKS-1:0]  stable_s;
  logic [N_TASKS-1:0]  committed_r;
  logic [N_TASKS-1:0]  commit_next_s;
  logic [ID_W-1:0]     id_next_s;
  logic [COLOUR_W-1:0] pix_next_s;

  switch_debouncer #(
    .WIDTH          (N_TASKS),
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (task_sw),
    .sw_sync   (sw_sync_s),
    .candidate (candidate_s),
    .stable    (stable_s)
  );

  // Priority encode: bit 0 wins; the debouncer only samples this on ticks.
  always_comb begin
    candidate_s = N_TASKS'(lowest_set(MAX_TASKS'(sw_sync_s)));
  end

  // Frame-aligned commit. stable_s is the pre-edge value, so a selection
  // that changes on a frame_begin cycle waits for the next frame.
  always_comb begin
    commit_next_s = committed_r;
    if (frame_begin) begin
      commit_next_s = stable_s;
    end else begin
      commit_next_s = committed_r;
    end
    id_next_s = onehot_to_id(MAX_TASKS'(commit_next_s));
  end

  // Colour of the currently committed task, default colour when idle.
  always_comb begin
    pix_next_s = {COLOUR_W{1'b0}};
    for (int k = 0; k < N_TASKS; k++) begin
      if (committed_r[k]) begin
        pix_next_s = colour_in[k*COLOUR_W +: COLOUR_W];
      end else begin
        pix_next_s = pix_next_s;
      end
    end
    if (committed_r == {N_TASKS{1'b0}}) begin
      pix_next_s = default_colour;
    end else begin
      pix_next_s = pix_next_s;
    end
  end

  // Committed selection and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      committed_r  <= {N_TASKS{1'b0}};
      active_id    <= NONE_ID;
      seg_en       <= 1'b1;
      switch_pulse <= 1'b0;
      pixel_out    <= {COLOUR_W{1'b0}};
    end else begin
      committed_r  <= commit_next_s;
      active_id    <= id_next_s;
      seg_en       <= (commit_next_s == {N_TASKS{1'b0}});
      switch_pulse <= frame_begin && (stable_s != committed_r);
      pixel_out    <= pix_next_s;
    end
  end

  assign task_en = committed_r;

endmodule

// File: tb/tb_task_display_mux.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model of the selection rules.
module tb_task_display_mux;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int TD = 4;
  localparam int DT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    task_sw;
  logic            frame_begin;
  logic [N*CW-1:0] colour_in;
  logic [CW-1:0]   default_colour;
  logic [N-1:0]    task_en;
  logic [4:0]      active_id;
  logic [CW-1:0]   pixel_out;
  logic            seg_en;
  logic            switch_pulse;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (post-edge view).
  logic [N-1:0]  m_s1, m_s2, m_stable, m_comm;
  int            m_tcnt;
  logic [N-1:0]  m_hist[$];
  logic [CW-1:0] m_pix;
  logic          m_pulse;

  always #5 clk = ~clk;

  task_display_mux #(
    .N_TASKS(N), .COLOUR_W(CW), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk(clk), .reset(reset), .task_sw(task_sw), .frame_begin(frame_begin),
    .colour_in(colour_in), .default_colour(default_colour),
    .task_en(task_en), .active_id(active_id), .pixel_out(pixel_out),
    .seg_en(seg_en), .switch_pulse(switch_pulse)
  );

  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] && r == '0) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 31;
  endfunction

  // True when the coming edge is a tick that completes a new stable run.
  function automatic bit stable_change_pending();
    logic [N-1:0] c;
    int sz;
    c  = lowest(m_s2);
    sz = m_hist.size();
    if (reset || m_tcnt != TD - 1 || c == m_stable || sz < DT - 1) return 1'b0;
    for (int i = sz - (DT - 1); i < sz; i++) begin
      if (m_hist[i] != c) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [N-1:0] cand;
    bit tk, same;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_tcnt = 0; m_hist.delete();
      m_stable = '0; m_comm = '0; m_pix = '0; m_pulse = 1'b0;
    end else begin
      tk      = (m_tcnt == TD - 1);
      m_tcnt  = (m_tcnt + 1) % TD;
      cand    = lowest(m_s2);
      m_pulse = frame_begin && (m_stable != m_comm);
      m_pix   = (m_comm == '0) ? default_colour : colour_in[idx_of(m_comm)*CW +: CW];
      if (frame_begin) m_comm = m_stable;
      if (tk) begin
        m_hist.push_back(cand);
        if (m_hist.size() > DT) void'(m_hist.pop_front());
        same = (m_hist.size() == DT);
        foreach (m_hist[i]) if (m_hist[i] != cand) same = 1'b0;
        if (same) m_stable = cand;
      end
      m_s2 = m_s1;
      m_s1 = task_sw;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("task_en", 32'(task_en), 32'(m_comm));
    check("active_id", 32'(active_id), (m_comm == '0) ? 32'd31 : 32'(idx_of(m_comm)));
    check("seg_en", 32'(seg_en), 32'(m_comm == '0));
    check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
    check("pixel_out", 32'(pixel_out), 32'(m_pix));
  endtask

  // One clock: update the model, let the edge pass, compare.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    reset = 1'b1; task_sw = '0; frame_begin = 1'b0;
    colour_in = 64'h4444_3333_2222_1111;
    default_colour = 16'h07E0;
    steps(3);
    check("rst_task_en", 32'(task_en), 32'h0);
    check("rst_active_id", 32'(active_id), 32'd31);
    check("rst_pixel", 32'(pixel_out), 32'h0);
    check("rst_seg_en", 32'(seg_en), 32'h1);
    check("rst_pulse", 32'(switch_pulse), 32'h0);

    // Two requests: lower index wins, commits at frame_begin.
    reset = 1'b0; task_sw = 4'b0110;
    steps(16);
    frame_begin = 1'b1; step(); frame_begin = 1'b0;
    check("sel_task_en", 32'(task_en), 32'h2);
    check("sel_id", 32'(active_id), 32'd1);
    check("sel_seg", 32'(seg_en), 32'h0);
    check("sel_pulse", 32'(switch_pulse), 32'h1);
    step();
    check("sel_pixel", 32'(pixel_out), 32'h2222);
    check("sel_pulse_once", 32'(switch_pulse), 32'h0);

    // Bouncing bit 2: selection must not move.
    for (int t = 0; t < 6; t++) begin
      task_sw = (t % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int c = 0; c < 8; c++) begin
        frame_begin = (c == 0);
        step();
        if (c == 0) check("bounce_hold", 32'(task_en), 32'h2);
      end
    end
    task_sw = 4'b0100;
    for (int c = 0; c < 32; c++) begin
      frame_begin = (c % 8 == 0);
      step();
    end
    frame_begin = 1'b0;
    check("bounce_commit", 32'(task_en), 32'h4);

    // Stable changes exactly on a frame_begin cycle.
    task_sw = 4'b0001; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      frame_begin = stable_change_pending();
      step();
      if (frame_begin) found = 1'b1;
    end
    frame_begin = 1'b0;
    check("race_found", 32'(found), 32'h1);
    check("race_old", 32'(task_en), 32'h4);
    check("race_no_pulse", 32'(switch_pulse), 32'h0);
    steps(3);
    frame_begin = 1'b1; step(); frame_begin = 1'b0;
    check("race_new", 32'(task_en), 32'h1);
    check("race_pulse", 32'(switch_pulse), 32'h1);

    // Release all switches: back to default colour and 7-segment.
    task_sw = 4'b0000;
    steps(20);
    frame_begin = 1'b1; step(); frame_begin = 1'b0;
    check("idle_task_en", 32'(task_en), 32'h0);
    check("idle_id", 32'(active_id), 32'd31);
    check("idle_seg", 32'(seg_en), 32'h1);
    check("idle_pulse", 32'(switch_pulse), 32'h1);
    step();
    check("idle_pixel", 32'(pixel_out), 32'h07E0);

    // Reset in the middle of a debounce run.
    task_sw = 4'b1000;
    steps(6);
    reset = 1'b1; steps(2);
    check("mid_rst_task_en", 32'(task_en), 32'h0);
    check("mid_rst_id", 32'(active_id), 32'd31);
    check("mid_rst_seg", 32'(seg_en), 32'h1);
    reset = 1'b0;
    frame_begin = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      check("mid_rst_early", 32'(task_en), 32'h0);
    end
    step();
    frame_begin = 1'b0;
    check("mid_rst_commit", 32'(task_en), 32'h8);
    check("mid_rst_pulse", 32'(switch_pulse), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      colour_in = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) task_sw = N'($urandom());
      if ($urandom_range(0, 63) == 0) default_colour = CW'($urandom());
      frame_begin = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
